// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and
// bit-period arithmetic used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DefaultCyclesPerBit = 868;  // 100 MHz / 115200
    localparam int unsigned DefaultDataBits     = 8;

    typedef logic [63:0] period_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic period_t bit_period(input int unsigned cycles_per_bit,
                                           input logic [31:0]  prescaler);
        return period_t'(cycles_per_bit) * (period_t'(prescaler) + period_t'(1));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs (rx, buttons, gpio).
// Both stages reset to ResetVal so the idle level is seen from the first cycle.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_error pulse output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CyclesPerBit = DefaultCyclesPerBit,
    parameter int unsigned DataBits     = DefaultDataBits
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         prescaler,
    input  logic                rx,
    output logic [DataBits-1:0] data,
    output logic                valid,
    input  logic                ready,
    output logic                busy,
    output logic                framing_error,
    output logic                overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                parity_error
`endif
);

    localparam int unsigned BitIdxW = (DataBits > 1) ? $clog2(DataBits) : 1;

    uart_rx_state_t      state, state_next;
    logic                rx_s;
    period_t             period, cnt, period_new;
    logic [BitIdxW-1:0]  bit_idx;
    logic [DataBits-1:0] shreg;
    logic                cnt_zero, last_bit;
    logic                start_frame, shift_en, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                par_bit, parity_en;
`endif

    sync_2ff #(.ResetVal(1'b1)) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d       (rx),
        .q       (rx_s)
    );

    assign cnt_zero   = (cnt == '0);
    assign last_bit   = (bit_idx == BitIdxW'(DataBits - 1));
    assign period_new = bit_period(CyclesPerBit, prescaler);

    always_ff @(posedge clk_i) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin : next_state
        // NOTE: default assignment first so no path through the case infers a latch.
        state_next = state;
        unique case (state)
            IDLE:   if (!rx_s) state_next = START;
            START:  if (cnt_zero) state_next = rx_s ? IDLE : DATA;
            DATA:   if (cnt_zero && last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
            PARITY: if (cnt_zero) state_next = STOP;
            STOP:   if (cnt_zero) state_next = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin : outputs_comb
        busy        = (state != IDLE);
        start_frame = (state == IDLE) && !rx_s;
        shift_en    = (state == DATA) && cnt_zero;
        stop_ok     = (state == STOP) && cnt_zero && rx_s;
        stop_bad    = (state == STOP) && cnt_zero && !rx_s;
`ifdef UART_RX_PARITY_EN
        parity_en   = (state == PARITY) && cnt_zero;
`endif
    end

    // Bit timer: half a period to the start-bit centre, then whole periods.
    always_ff @(posedge clk_i) begin : bit_timer
        if (reset_i) begin
            period  <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (start_frame) begin
                period <= period_new;
                cnt    <= (period_new >> 1) - period_t'(1);
            end else if (state != IDLE && state != BREAK) begin
                cnt <= cnt_zero ? period - period_t'(1) : cnt - period_t'(1);
            end

            if (state == START) bit_idx <= '0;
            if (shift_en) begin
                shreg   <= DataBits'({rx_s, shreg} >> 1);
                bit_idx <= bit_idx + BitIdxW'(1);
            end
`ifdef UART_RX_PARITY_EN
            if (parity_en) par_bit <= rx_s;
`endif
        end
    end

    // Holding register: a consume in the stop-sample cycle makes room for the new byte.
    always_ff @(posedge clk_i) begin : delivery
        if (reset_i) begin
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            framing_error <= stop_bad;
            overrun       <= stop_ok && valid && !ready;
`ifdef UART_RX_PARITY_EN
            parity_error  <= stop_ok && ((^shreg) ^ par_bit);
`endif
            if (stop_ok && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames, compared
// every cycle against a frame-level event model of the receiver.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;
    localparam int unsigned Db  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif

    logic        clk_i     = 1'b0;
    logic        reset_i   = 1'b1;
    logic [31:0] prescaler = '0;
    logic        rx        = 1'b1;
    logic        ready     = 1'b0;
    logic [7:0]  data;
    logic        valid, busy, framing_error, overrun;
`ifdef UART_RX_PARITY_EN
    logic        parity_error;
`endif

    uart_rx #(.CyclesPerBit(Cpb), .DataBits(Db)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .prescaler     (prescaler),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .busy          (busy),
        .framing_error (framing_error),
        .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned at;
        logic [7:0]  b;
        bit          stop_ok;
        bit          par_err;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  xfer_q[$];
    ev_t         ev;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          m_valid = 1'b0, m_fe, m_ovr, m_perr, take;
    logic [7:0]  m_data = '0;
    int unsigned ov_cnt = 0, fe_cnt = 0, busy_cnt = 0, rise_cyc = 0, last_tfall = 0;
    bit          valid_q = 1'b0;
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: each frame posts a delivery event at its stop-sample cycle.
    always @(posedge clk_i) begin
        cyc   = cyc + 1;
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        m_perr = 1'b0;
        if (reset_i) begin
            m_valid = 1'b0;
            m_data  = '0;
            exp_q.delete();
        end else begin
            take = m_valid && ready;
            if (take) begin
                xfer_q.push_back(m_data);
                m_valid = 1'b0;
            end
            if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
                ev = exp_q.pop_front();
                if (!ev.stop_ok) m_fe = 1'b1;
                else begin
                    if (m_valid) m_ovr = 1'b1;
                    else begin
                        m_valid = 1'b1;
                        m_data  = ev.b;
                    end
                    m_perr = ev.par_err;
                end
            end
        end
        #1;
        check("valid", valid, m_valid);
        check("data", data, m_data);
        check("framing_error", framing_error, m_fe);
        check("overrun", overrun, m_ovr);
`ifdef UART_RX_PARITY_EN
        check("parity_error", parity_error, m_perr);
`endif
        if (valid && !valid_q) rise_cyc = cyc;
        valid_q  = valid;
        ov_cnt   += overrun;
        fe_cnt   += framing_error;
        busy_cnt += busy;
    end

    task automatic tick();
        @(negedge clk_i);
        if (rand_rdy) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic drain();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check("drained", valid, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input int unsigned presc, input bit bad_stop,
                              input bit bad_par, input int unsigned stop_len, input int abort_bit,
                              input bit chg_presc);
        int unsigned p;
        p          = Cpb * (presc + 1);
        prescaler  = presc;
        rx         = 1'b0;
        last_tfall = cyc;
        exp_q.push_back('{last_tfall + 2 + p / 2 + (Db + ParBits + 1) * p + 1, b, !bad_stop, bad_par});
        idle(p);
        for (int i = 0; i < int'(Db); i++) begin
            rx = b[i];
            if (i == 4) begin
                idle(p / 2);
                if (i == abort_bit) begin
                    reset_i = 1'b1;
                    rx      = 1'b1;
                    tick();
                    check("rst_mid_busy", busy, 0);
                    check("rst_mid_valid", valid, 0);
                    check("rst_mid_data", data, 0);
                    reset_i = 1'b0;
                    return;
                end
                check("busy_mid_frame", busy, 1);
                if (chg_presc) prescaler = 32'd7;
                idle(p - p / 2);
            end else begin
                idle(p);
            end
        end
        if (ParBits != 0) begin
            rx = (^b) ^ bad_par;
            idle(p);
        end
        rx = !bad_stop;
        idle(stop_len);
        rx = 1'b1;
    endtask

    int unsigned ov0, fe0, b0, xs, p, gap;
    logic [7:0]  rb;
    int unsigned rpresc;
    bit          rbad_stop, rbad_par;

    initial begin
        idle(3);
        reset_i = 1'b0;
        tick();
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_fe", framing_error, 0);
        check("rst_ovr", overrun, 0);
        idle(5);

        // 1: single byte, latency
        ov0 = ov_cnt; fe0 = fe_cnt;
        send_frame(8'hA5, 0, 0, 0, Cpb, -1, 0);
        idle(4);
        check("a5_latency", rise_cyc - last_tfall, (ParBits != 0) ? 171 : 155);
        check("a5_data", data, 8'hA5);
        check("a5_valid", valid, 1);
        check("a5_no_ovr", ov_cnt - ov0, 0);
        check("a5_no_fe", fe_cnt - fe0, 0);
        drain();

        // 2: back-to-back with and without consumer
        ov0 = ov_cnt;
        send_frame(8'h3C, 0, 0, 0, Cpb, -1, 0);
        send_frame(8'h7E, 0, 0, 0, Cpb, -1, 0);
        idle(4);
        check("b2b_ovr_once", ov_cnt - ov0, 1);
        check("b2b_keep_old", data, 8'h3C);
        ready = 1'b1;
        tick();
        xs = xfer_q.size(); ov0 = ov_cnt;
        send_frame(8'h3C, 0, 0, 0, Cpb, -1, 0);
        send_frame(8'h7E, 0, 0, 0, Cpb, -1, 0);
        idle(4);
        check("b2b_xfer_cnt", xfer_q.size() - xs, 2);
        if (xfer_q.size() >= xs + 2) begin
            check("b2b_xfer0", xfer_q[xs], 8'h3C);
            check("b2b_xfer1", xfer_q[xs + 1], 8'h7E);
        end
        check("b2b_rdy_no_ovr", ov_cnt - ov0, 0);
        ready = 1'b0;
        tick();

        // 3: held-low stop bit
        fe0 = fe_cnt;
        send_frame(8'h55, 0, 1, 0, 40 * Cpb, -1, 0);
        idle(Cpb);
        check("brk_fe_once", fe_cnt - fe0, 1);
        check("brk_no_valid", valid, 0);
        send_frame(8'h12, 0, 0, 0, Cpb, -1, 0);
        idle(4);
        check("brk_next_data", data, 8'h12);
        check("brk_next_valid", valid, 1);
        check("brk_idle", busy, 0);
        drain();

        // 4: start glitch
        b0 = busy_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(2 * Cpb);
        check("glitch_busy_seen", busy_cnt != b0, 1);
        check("glitch_idle", busy, 0);
        check("glitch_no_valid", valid, 0);
        check("glitch_no_err", (ov_cnt - ov0) + (fe_cnt - fe0), 0);

        // 5: prescaler
        send_frame(8'h81, 2, 0, 0, 3 * Cpb, -1, 0);
        idle(4);
        check("presc_data", data, 8'h81);
        drain();
        send_frame(8'h81, 2, 0, 0, 3 * Cpb, -1, 1);
        idle(4);
        check("presc_chg_data", data, 8'h81);
        check("presc_chg_valid", valid, 1);
        prescaler = '0;
        drain();

        // 6: reset mid-frame
        send_frame(8'hF0, 0, 0, 0, Cpb, 4, 0);
        idle(2 * Cpb);
        check("rst_abort_valid", valid, 0);
        send_frame(8'hF0, 0, 0, 0, Cpb, -1, 0);
        idle(4);
        check("after_rst_data", data, 8'hF0);
        check("after_rst_valid", valid, 1);
        drain();

        // Randomized frames with a random consumer
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rb        = 8'($urandom);
            rpresc    = $urandom_range(0, 1);
            rbad_stop = ($urandom_range(0, 9) == 0);
            rbad_par  = (ParBits != 0) && ($urandom_range(0, 7) == 0);
            p         = Cpb * (rpresc + 1);
            send_frame(rb, rpresc, rbad_stop, rbad_par, p, -1, 0);
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, p) : 0;
            if (rbad_stop) gap += p;
            idle(gap);
        end
        rand_rdy = 1'b0;
        ready    = 1'b1;
        idle(4 * Cpb);
        ready    = 1'b0;
        idle(4);
        check("final_drained", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the 8N1 serial line, the receive counterpart of the existing uart transmitter. It synchronises the asynchronous rx pin, detects start bits, samples each bit at mid-bit and assembles bytes LSB first. Received bytes are held in a one-entry holding register and offered on a valid/ready interface to a downstream rx fifo/CSR. Framing errors and overruns are flagged with single-cycle pulses.

Parameters:
CyclesPerBit, 868, base clock cycles per bit at prescaler=0 (100 MHz / 115200); must be >= 4.
DataBits, 8, data bits per frame.

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
prescaler  in  32  bit period = CyclesPerBit*(prescaler+1) cycles; sampled only in IDLE
rx  in  1  asynchronous serial input, idle high
data  out  DataBits  received byte; holding register
valid  out  1  data holds an unconsumed byte
ready  in  1  consumer accepts; transfer when valid&&ready
busy  out  1  frame reception in progress (state != IDLE)
framing_error  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: byte completed while valid=1 and ready=0; new byte dropped

Behaviour:
- Clock clk_i; reset_i is synchronous and active-high.
- Reset: state=IDLE, data=0, valid=0, busy=0, framing_error=0, overrun=0, synchroniser flops=1, counters=0.
- rx passes through a 2-FF synchroniser (reset value 1); rx_s is the synchronised signal. All decisions use rx_s.
- Latch bit period P = CyclesPerBit*(prescaler+1) on leaving IDLE. Prescaler changes mid-frame are ignored.
- States:
  - IDLE: on rx_s=0, go to START and load the counter with P/2-1 (integer division).
  - START: when the counter reaches 0, sample rx_s. If 0, go to DATA with bit index 0 and counter P-1. If 1 (glitch), return to IDLE with no error.
  - DATA: at counter 0, shift rx_s into the shift register MSB and shift right, so the byte ends LSB first. Reload P-1. After bit DataBits-1 is sampled, go to STOP.
  - STOP: at counter 0, sample rx_s.
    - If 1: deliver the byte (see below) and go to IDLE.
    - If 0: pulse framing_error, discard the byte and go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. Held-low lines produce exactly one framing_error.
- Delivery, in the cycle after the stop sample:
  - valid=0: data<=byte, valid<=1.
  - valid=1 and ready=1 in the stop-sample cycle: the old byte is consumed and the new byte loaded. No overrun.
  - valid=1 and ready=0: pulse overrun and keep the old byte.
- Handshake: valid drops the cycle after valid&&ready unless a new byte loads in that same cycle. data is stable while valid=1 and not consumed. ready is ignored while valid=0.
- Latency: valid rises 2 + floor(P/2) + (DataBits+1)*P + 1 cycles (±1) after the rx pin falls.
- The receiver returns to IDLE at mid-stop-bit, so back-to-back frames with zero idle time are received.
- reset_i asserted mid-frame aborts the frame immediately, with no pulses. After release the FSM waits in IDLE for the next falling edge; a line that is already low counts as a start.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit. If the even parity of data plus the parity bit is violated, the port parity_error (out, 1) pulses in the delivery cycle. The byte is still delivered.
- Undefined: the frame is 8N1, there is no PARITY state, and the parity_error port is absent.

Decomposition:
- Put in uart_pkg:
  - typedef uart_rx_state_t: IDLE, START, DATA, PARITY, STOP, BREAK.
  - DataBits default.
  - Default CyclesPerBit, shared with the transmitter.
- Sub-module sync_2ff (parameter ResetVal) for the synchroniser. It is reusable for the btn and gpio inputs.

Test Plan:
All cases use CyclesPerBit=16, prescaler=0 unless stated.
1. Drive byte 0xA5 8N1 with ready=0 -> valid=1, data=0xA5 at the specified latency (±1); no error pulses.
2. Send 0x3C with ready=0, then 0x7E back to back with no idle gap -> overrun pulses once; data stays 0x3C. Repeat with ready=1 held -> bytes 0x3C then 0x7E transfer, no overrun.
3. Stop bit held low for 0x55, line low for 40 bit times -> exactly one framing_error pulse; valid stays 0. After the line goes high, 0x12 is received correctly.
4. 3-cycle low glitch on idle rx -> busy pulses, returns to IDLE; no valid, no errors.
5. prescaler=2 (P=48), byte 0x81 -> received correctly. Changing prescaler mid-frame does not corrupt 0x81.
6. reset_i asserted for 1 cycle at data bit 4 -> all outputs return to reset values. The next full frame 0xF0 is received correctly.
